// File: rtl/if_id_elastic_reg.sv
// IF->ID pipeline register with a valid/ready handshake and an optional 2-entry skid buffer.
// Latency 1 cycle. With SKID_EN=1, in_ready is registered. With SKID_EN=0, in_ready follows out_ready combinationally.
module if_id_elastic_reg #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter bit                 SKID_EN   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic               in_ready_q, in_ready_d;
    logic               accept, consume;

    assign in_ready  = SKID_EN ? in_ready_q : (out_ready | ~out_valid_q);
    assign out_valid = out_valid_q;
    assign out_instr = main_instr_q;
    assign out_pc    = main_pc_q;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid_q & out_ready;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc_d    = main_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d      = ST_FULL;
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                end
            end
            ST_FULL: begin
                if (accept && consume) begin
                    main_instr_d = in_instr;
                    main_pc_d    = in_pc;
                end else if (accept) begin
                    // Without a skid entry, in_ready already guarantees consume here.
                    if (SKID_EN) begin
                        state_d      = ST_SKID;
                        skid_instr_d = in_instr;
                        skid_pc_d    = in_pc;
                    end
                end else if (consume) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (consume) begin
                    state_d      = ST_FULL;
                    main_instr_d = skid_instr_q;
                    main_pc_d    = skid_pc_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (flush) begin
            state_d = ST_EMPTY;
        end

        // An empty register always shows a clean bubble, so decode may ignore out_valid.
        if (state_d == ST_EMPTY) begin
            main_instr_d = NOP_INSTR;
            main_pc_d    = '0;
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_SKID);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            out_valid_q  <= 1'b0;
            main_instr_q <= NOP_INSTR;
            main_pc_q    <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            main_instr_q <= main_instr_d;
            main_pc_q    <= main_pc_d;
            in_ready_q   <= in_ready_d;
        end
    end

    // Skid contents are only meaningful in ST_SKID, so they need no reset.
    always_ff @(posedge clk) begin
        skid_instr_q <= skid_instr_d;
        skid_pc_q    <= skid_pc_d;
    end

endmodule

// File: tb/tb_if_id_elastic_reg.sv
// Bench for if_id_elastic_reg: the default skid configuration is checked with a scoreboard and monitor.
// A second, single-entry instance with a non-zero NOP checks that in_ready responds to out_ready in the same cycle.
module tb_if_id_elastic_reg;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_instr, out_pc;

    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0;
    logic [31:0] in_instr0, in_pc0, out_instr0, out_pc0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_pc, prev_instr;
    logic [31:0] stream_instr [3] = '{32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003};

    always #5 clk = ~clk;

    if_id_elastic_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
    );

    if_id_elastic_reg #(.NOP_INSTR(32'h00000013), .SKID_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_instr(in_instr0), .in_pc(in_pc0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_instr(out_instr0), .out_pc(out_pc0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] instr, input bit expect_out);
        in_valid = 1'b1;
        in_pc    = pc;
        in_instr = instr;
        if (expect_out) exp_q.push_back('{instr: instr, pc: pc});
    endtask

    // Monitor: pops the scoreboard on every consume, checks bubbles and stall stability.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (prev_stall) begin
                    check("stall_pc_stable", out_pc, prev_pc);
                    check("stall_instr_stable", out_instr, prev_instr);
                end
                if (out_ready === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: actual pc %h instr %h required none", out_pc, out_instr);
                    end else begin
                        e = exp_q.pop_front();
                        check("order_pc", out_pc, e.pc);
                        check("order_instr", out_instr, e.instr);
                    end
                end
            end else begin
                check("bubble_instr", out_instr, 32'h0);
                check("bubble_pc", out_pc, 32'h0);
            end
            prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
            prev_pc    = out_pc;
            prev_instr = out_instr;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        flush0 = 1'b0; in_valid0 = 1'b0; in_instr0 = '0; in_pc0 = '0; out_ready0 = 1'b0;
        tick;
        tick;
        rst    = 1'b0;
        mon_en = 1'b1;

        // 1: reset state
        @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        tick;

        // 2: streaming at full rate, one-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(32'(4 * (i + 1)), stream_instr[i], 1'b1);
            @(negedge clk);
            check("stream_in_ready", {31'b0, in_ready}, 32'd1);
            if (i > 0) check("stream_latency_pc", out_pc, 32'(4 * i));
            tick;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last_pc", out_pc, 32'd12);
        tick;
        @(negedge clk);
        check("stream_drained", {31'b0, out_valid}, 32'd0);
        tick;

        // 3: stall fills the skid entry
        out_ready = 1'b0;
        offer(32'd4, 32'hD0000004, 1'b1);
        tick;
        offer(32'd8, 32'hE0000008, 1'b1);
        @(negedge clk);
        check("full_in_ready", {31'b0, in_ready}, 32'd1);
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("skid_in_ready", {31'b0, in_ready}, 32'd0);
            check("skid_hold_pc", out_pc, 32'd4);
            tick;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("skid_drain_pc0", out_pc, 32'd4);
        tick;
        @(negedge clk);
        check("skid_drain_pc1", out_pc, 32'd8);
        check("skid_drain_in_ready", {31'b0, in_ready}, 32'd1);
        tick;
        @(negedge clk);
        check("skid_drained", {31'b0, out_valid}, 32'd0);
        tick;

        // 4: flush in SKID while a third word is offered
        out_ready = 1'b0;
        offer(32'd4, 32'hF0000004, 1'b1);
        tick;
        offer(32'd8, 32'hF0000008, 1'b1);
        tick;
        offer(32'd12, 32'hF000000C, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        check("preflush_in_ready", {31'b0, in_ready}, 32'd0);
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_out_instr", out_instr, 32'h0);
        check("flush_out_pc", out_pc, 32'h0);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        tick;
        // flush drops a word even when in_ready=1
        offer(32'd16, 32'hF0000010, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_empty_in_ready", {31'b0, in_ready}, 32'd1);
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_drop_out_valid", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        tick;
        tick;

        // 5: reset mid-stream while stalled
        out_ready = 1'b0;
        offer(32'd20, 32'h12340014, 1'b1);
        tick;
        offer(32'd24, 32'h12340018, 1'b0);
        rst = 1'b1;
        tick;
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst2_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst2_out_instr", out_instr, 32'h0);
        check("rst2_out_pc", out_pc, 32'h0);
        check("rst2_in_ready", {31'b0, in_ready}, 32'd1);
        tick;

        // 6: single-entry variant with non-zero NOP
        @(negedge clk);
        check("s0_rst_instr", out_instr0, 32'h00000013);
        check("s0_rst_in_ready", {31'b0, in_ready0}, 32'd1);
        in_valid0 = 1'b1;
        in_pc0    = 32'd4;
        in_instr0 = 32'h00A00093;
        tick;
        in_valid0 = 1'b0;
        @(negedge clk);
        check("s0_full_valid", {31'b0, out_valid0}, 32'd1);
        check("s0_full_pc", out_pc0, 32'd4);
        check("s0_stall_in_ready", {31'b0, in_ready0}, 32'd0);
        out_ready0 = 1'b1;
        #1;
        check("s0_comb_in_ready", {31'b0, in_ready0}, 32'd1);
        out_ready0 = 1'b0;
        flush0     = 1'b1;
        tick;
        flush0 = 1'b0;
        @(negedge clk);
        check("s0_flush_valid", {31'b0, out_valid0}, 32'd0);
        check("s0_flush_instr", out_instr0, 32'h00000013);
        check("s0_flush_pc", out_pc0, 32'h0);
        check("s0_flush_in_ready", {31'b0, in_ready0}, 32'd1);
        tick;

        mon_en = 1'b0;
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
